// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx byte transmitter among NUM_REQ requesters. Ownership is
//   granted per packet: the owner keeps the transmitter until a byte flagged
//   last is accepted. Requesters are served round-robin between packets.
//
// Ports
//   clock      in   1          system clock, all logic on posedge
//   reset_n    in   1          asynchronous active-low reset
//   req_valid  in   NUM_REQ    per-requester byte valid
//   req_data   in   8*NUM_REQ  requester i byte on [8*i+7:8*i]
//   req_last   in   NUM_REQ    presented byte ends the requester's packet
//   req_ready  out  NUM_REQ    accept; only the owner's bit can be 1
//   tx_byte    out  8          byte to uart_tx
//   tx_valid   out  1          valid to uart_tx
//   tx_ready   in   1          ready from uart_tx
//   grant      out  NUM_REQ    registered one-hot owner, zero when idle
//   busy       out  1          packet in progress
//
// Configuration
//   UART_ARB_TIMEOUT_EN : when defined, an owner that makes no handshake for
//   TIMEOUT_CYCLES consecutive cycles loses the grant and its packet is dropped.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_busy;

  logic               w_any;
  logic [IDX_W-1:0]   w_winner;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_byte;
  logic               w_hs;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   r_cnt;
`endif

  // Round-robin search: ptr+1, ptr+2, ... wrapping. Scanning from the farthest
  // candidate down lets the nearest valid requester overwrite the result last.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_any    = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[v_idx]) begin
        w_any    = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // Owner pass-through; r_owner is only meaningful while busy.
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_own_byte  = req_data[{r_owner, 3'b000} +: 8];
  assign w_hs        = r_busy & w_own_valid & tx_ready;

  assign tx_valid  = r_busy & w_own_valid;
  assign tx_byte   = r_busy ? w_own_byte : 8'h00;
  assign req_ready = r_grant & {NUM_REQ{tx_ready}};
  assign grant     = r_grant;
  assign busy      = r_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_busy  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_OWN;
            r_grant <= NUM_REQ'(1) << w_winner;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_OWN: begin
          // Release goes to IDLE only; the next arbitration happens one cycle
          // later, so the releasing owner becomes lowest priority.
          if (w_hs && w_own_last) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_owner;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_hs) begin
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= r_owner;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
